// File: rtl/axis_cmd_sequencer_pkg.sv
// Shared types for the descriptor sequencer: opcodes, mover instruction codes, FSM states, descriptor layout.
// Holds the descriptor validity rule so that the queue-side and checker-side views of a descriptor agree.
package axis_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_WRITE  = 2'b01,
        OP_READ   = 2'b10,
        OP_NOTIFY = 2'b11
    } op_e;

    localparam logic [7:0] INSTR_NONE  = 8'h00;
    localparam logic [7:0] INSTR_WRITE = 8'h01;
    localparam logic [7:0] INSTR_READ  = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  bram_start;
        logic [4:0]  bram_end;
        logic [15:0] addr_start;
        logic [15:0] addr_count;
    } desc_t;

    localparam int DESC_W = $bits(desc_t);

    // Read-side BRAM indices are only 3 bits wide on the mover, hence the be>7 rule.
    function automatic logic desc_bad(input desc_t d, input int bram_count);
        logic [5:0] lim;
        lim = 6'(bram_count);
        return (d.op == OP_NOP) || (d.bram_end < d.bram_start) ||
               ({1'b0, d.bram_end} >= lim) || (d.addr_count == 16'd0) ||
               ((d.op != OP_WRITE) && (d.bram_end > 5'd7));
    endfunction

endpackage

// File: rtl/axis_cmd_sequencer_desc_fifo.sv
// Descriptor queue, first-word-fall-through head; push to head visible next cycle.
// Backpressure: a push is dropped when full unless a pop happens in the same cycle.
module axis_cmd_sequencer_desc_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (level != '0);
    assign do_push = push && ((level != LW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axis_cmd_sequencer.sv
// Queues mover descriptors and issues them one at a time; 3 cycles from pop to instruction, done seen combinationally.
// Backpressure: cmd_ready drops when the queue is full; a timeout halts popping until err_clear.
module axis_cmd_sequencer
    import axis_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int BRAM_COUNT     = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [4:0]                        cmd_bram_start,
    input  logic [4:0]                        cmd_bram_end,
    input  logic [15:0]                       cmd_addr_start,
    input  logic [15:0]                       cmd_addr_count,
    output logic [7:0]                        mvr_instruction,
    output logic [4:0]                        mvr_wr_bram_start,
    output logic [4:0]                        mvr_wr_bram_end,
    output logic [15:0]                       mvr_wr_addr_start,
    output logic [15:0]                       mvr_wr_addr_count,
    output logic [2:0]                        mvr_rd_bram_start,
    output logic [2:0]                        mvr_rd_bram_end,
    output logic [15:0]                       mvr_rd_addr_start,
    output logic [15:0]                       mvr_rd_addr_count,
    output logic                              mvr_notify_mode,
    input  logic                              mvr_write_done,
    input  logic                              mvr_read_done,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   queue_level,
    output logic [15:0]                       done_count,
    output logic                              err_bad_cmd,
    output logic                              err_timeout,
    input  logic                              err_clear
);
    localparam int          LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_e            state;
    desc_t             desc;
    desc_t             in_desc;
    logic [DESC_W-1:0] head_dat;
    logic [7:0]        instr_q;
    logic [19:0]       tmo_cnt;
    logic              push;
    logic              pop;
    logic              exp_done;
    logic              done_hit;
    logic              tmo_hit;

    assign in_desc   = '{op: op_e'(cmd_op), bram_start: cmd_bram_start, bram_end: cmd_bram_end,
                         addr_start: cmd_addr_start, addr_count: cmd_addr_count};
    assign cmd_ready = (queue_level < LVL_W'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && (queue_level != '0) && !err_timeout;
    assign exp_done  = (desc.op == OP_WRITE) ? mvr_write_done : mvr_read_done;
    assign done_hit  = (state == ST_WAIT) && exp_done;
    assign tmo_hit   = (state == ST_WAIT) && !exp_done && (tmo_cnt == TMO_LAST);

    // Masking with the done keeps the mover from re-triggering on a stale code once it returns to idle.
    assign mvr_instruction = instr_q & ~{8{done_hit}};

    axis_cmd_sequencer_desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .push     (push),
        .push_dat (in_desc),
        .pop      (pop),
        .head     (head_dat),
        .level    (queue_level)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            desc              <= '0;
            instr_q           <= INSTR_NONE;
            tmo_cnt           <= '0;
            busy              <= 1'b0;
            done_count        <= '0;
            err_bad_cmd       <= 1'b0;
            err_timeout       <= 1'b0;
            mvr_wr_bram_start <= '0;
            mvr_wr_bram_end   <= '0;
            mvr_wr_addr_start <= '0;
            mvr_wr_addr_count <= '0;
            mvr_rd_bram_start <= '0;
            mvr_rd_bram_end   <= '0;
            mvr_rd_addr_start <= '0;
            mvr_rd_addr_count <= '0;
            mvr_notify_mode   <= 1'b0;
        end else begin
            // Later error assignments override this, so a same-cycle error wins.
            if (err_clear) begin
                err_bad_cmd <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        desc  <= desc_t'(head_dat);
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (desc_bad(desc, BRAM_COUNT)) begin
                        state <= ST_IDLE;
                        if (desc.op != OP_NOP) err_bad_cmd <= 1'b1;
                    end else begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (desc.op == OP_WRITE) begin
                        mvr_wr_bram_start <= desc.bram_start;
                        mvr_wr_bram_end   <= desc.bram_end;
                        mvr_wr_addr_start <= desc.addr_start;
                        mvr_wr_addr_count <= desc.addr_count;
                        instr_q           <= INSTR_WRITE;
                    end else begin
                        mvr_rd_bram_start <= desc.bram_start[2:0];
                        mvr_rd_bram_end   <= desc.bram_end[2:0];
                        mvr_rd_addr_start <= desc.addr_start;
                        mvr_rd_addr_count <= desc.addr_count;
                        instr_q           <= INSTR_READ;
                    end
                    mvr_notify_mode <= (desc.op == OP_NOTIFY);
                    tmo_cnt         <= '0;
                    state           <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit || tmo_hit) begin
                        state             <= ST_IDLE;
                        busy              <= 1'b0;
                        instr_q           <= INSTR_NONE;
                        mvr_wr_bram_start <= '0;
                        mvr_wr_bram_end   <= '0;
                        mvr_wr_addr_start <= '0;
                        mvr_wr_addr_count <= '0;
                        mvr_rd_bram_start <= '0;
                        mvr_rd_bram_end   <= '0;
                        mvr_rd_addr_start <= '0;
                        mvr_rd_addr_count <= '0;
                        mvr_notify_mode   <= 1'b0;
                        if (done_hit) done_count <= done_count + 16'd1;
                        else          err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
